// File: rtl/instr_encoder_if.sv
// instr_encoder_if: groups the encoder's input-field handshake and its
// output-word handshake into one bundle.
//   master : the producer/consumer side (stimulus generator + word sink)
//   slave  : the encoder side
// Signals:
//   in_valid/in_ready            input handshake
//   instruction_type, opcode, funct3, funct7, rd, rs1, rs2, imm   fields
//   out_valid/out_ready          output handshake
//   instruction, err             head-of-buffer word and its error flag
//   count                        delivered-word counter
interface instr_encoder_if #(
  parameter int unsigned INSTRUCTION_LENGTH = 32,
  parameter int unsigned TYPE_WIDTH         = 3,
  parameter int unsigned REGISTER_WIDTH     = 5,
  parameter int unsigned IMMEDIATE_WIDTH    = 32,
  parameter int unsigned COUNT_WIDTH        = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic [TYPE_WIDTH-1:0]         instruction_type;
  logic [6:0]                    opcode;
  logic [2:0]                    funct3;
  logic [6:0]                    funct7;
  logic [REGISTER_WIDTH-1:0]     rd;
  logic [REGISTER_WIDTH-1:0]     rs1;
  logic [REGISTER_WIDTH-1:0]     rs2;
  logic [IMMEDIATE_WIDTH-1:0]    imm;
  logic                          out_valid;
  logic                          out_ready;
  logic [INSTRUCTION_LENGTH-1:0] instruction;
  logic                          err;
  logic [COUNT_WIDTH-1:0]        count;

  modport master (
    output in_valid, instruction_type, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instruction, err, count
  );

  modport slave (
    input  in_valid, instruction_type, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instruction, err, count
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction fields into a 32-bit word and queues
// it, together with an error flag, in a 2-entry output buffer.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; empties the buffer, clears count
//   bus    instr_encoder_if.slave (input fields + handshakes, word, err, count)
// Type codes: R=0, I=1, S=2, SB=3, U=4, UJ=5; 6 and 7 are undefined.
// Optional feature macro: ENCODER_RANGE_CHECK_EN -- flags immediates that the
// selected format cannot represent (the word is still packed from truncated
// fields). When undefined, err only marks undefined type codes.
module instr_encoder #(
  parameter int unsigned INSTRUCTION_LENGTH = 32,
  parameter int unsigned TYPE_WIDTH         = 3,
  parameter int unsigned REGISTER_WIDTH     = 5,
  parameter int unsigned IMMEDIATE_WIDTH    = 32,
  parameter int unsigned COUNT_WIDTH        = 16
) (
  input logic             clk,
  input logic             reset,
  instr_encoder_if.slave  bus
);

  localparam logic [TYPE_WIDTH-1:0] R_TYPE  = TYPE_WIDTH'(0);
  localparam logic [TYPE_WIDTH-1:0] I_TYPE  = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] S_TYPE  = TYPE_WIDTH'(2);
  localparam logic [TYPE_WIDTH-1:0] SB_TYPE = TYPE_WIDTH'(3);
  localparam logic [TYPE_WIDTH-1:0] U_TYPE  = TYPE_WIDTH'(4);
  localparam logic [TYPE_WIDTH-1:0] UJ_TYPE = TYPE_WIDTH'(5);

  typedef struct packed {
    logic                          err;
    logic [INSTRUCTION_LENGTH-1:0] word;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  logic [REGISTER_WIDTH-1:0]  rd;
  logic [REGISTER_WIDTH-1:0]  rs1;
  logic [REGISTER_WIDTH-1:0]  rs2;
  logic [IMMEDIATE_WIDTH-1:0] imm;

  assign rd  = bus.rd;
  assign rs1 = bus.rs1;
  assign rs2 = bus.rs2;
  assign imm = bus.imm;

  entry_t      enc_c;
  logic        type_err_c;
  logic        range_err_c;
  entry_t      head;
  entry_t      tail;
  fifo_state_e state;
  fifo_state_e state_next;
  logic        in_ready_c;
  logic        out_valid_c;
  logic        push_c;
  logic        pop_c;
  logic [COUNT_WIDTH-1:0] count;

  // Field packing per instruction format; undefined codes yield a zero word.
  always_comb begin
    enc_c.word = '0;
    type_err_c = 1'b0;
    case (bus.instruction_type)
      R_TYPE:  enc_c.word = INSTRUCTION_LENGTH'({bus.funct7, rs2, rs1, bus.funct3, rd, bus.opcode});
      I_TYPE:  enc_c.word = INSTRUCTION_LENGTH'({imm[11:0], rs1, bus.funct3, rd, bus.opcode});
      S_TYPE:  enc_c.word = INSTRUCTION_LENGTH'({imm[11:5], rs2, rs1, bus.funct3, imm[4:0], bus.opcode});
      SB_TYPE: enc_c.word = INSTRUCTION_LENGTH'({imm[12], imm[10:5], rs2, rs1, bus.funct3,
                                                 imm[4:1], imm[11], bus.opcode});
      U_TYPE:  enc_c.word = INSTRUCTION_LENGTH'({imm[31:12], rd, bus.opcode});
      UJ_TYPE: enc_c.word = INSTRUCTION_LENGTH'({imm[20], imm[10:1], imm[11], imm[19:12], rd, bus.opcode});
      default: type_err_c = 1'b1;
    endcase
    enc_c.err = type_err_c | range_err_c;
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = $signed(imm[31:0]);

  // Representability of the immediate in the selected format.
  always_comb begin
    range_err_c = 1'b0;
    case (bus.instruction_type)
      I_TYPE, S_TYPE: range_err_c = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      SB_TYPE:        range_err_c = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
      U_TYPE:         range_err_c = (imm[11:0] != 12'd0);
      UJ_TYPE:        range_err_c = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
      default:        range_err_c = 1'b0;
    endcase
  end
`else
  assign range_err_c = 1'b0;
`endif

  assign push_c = bus.in_valid && in_ready_c;
  assign pop_c  = out_valid_c && bus.out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Occupancy next state; push+pop together leaves occupancy unchanged.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (push_c) state_next = ONE;
      ONE: begin
        if (push_c && !pop_c)      state_next = FULL;
        else if (!push_c && pop_c) state_next = EMPTY;
      end
      FULL:    if (pop_c) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Handshake outputs decoded from the occupancy register only, so there is
  // no combinational path from out_ready to in_ready.
  always_comb begin
    in_ready_c  = 1'b1;
    out_valid_c = 1'b0;
    case (state)
      EMPTY:   begin in_ready_c = 1'b1; out_valid_c = 1'b0; end
      ONE:     begin in_ready_c = 1'b1; out_valid_c = 1'b1; end
      FULL:    begin in_ready_c = 1'b0; out_valid_c = 1'b1; end
      default: begin in_ready_c = 1'b1; out_valid_c = 1'b0; end
    endcase
  end

  // Head always holds the oldest entry; a new entry lands in head when the
  // buffer is (or is becoming) empty, otherwise behind it in tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (pop_c && (state == FULL)) head <= tail;
      if (push_c) begin
        if ((state == EMPTY) || pop_c) head <= enc_c;
        else                           tail <= enc_c;
      end
    end
  end

  // Delivered-word counter; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (pop_c) count <= count + COUNT_WIDTH'(1);
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.instruction = head.word;
  assign bus.err         = head.err;
  assign bus.count       = count;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed stimulus for instr_encoder,
// checked every cycle against a queue-based reference model.
module tb_instr_encoder;

  localparam logic [2:0] T_R  = 3'd0;
  localparam logic [2:0] T_I  = 3'd1;
  localparam logic [2:0] T_S  = 3'd2;
  localparam logic [2:0] T_SB = 3'd3;
  localparam logic [2:0] T_U  = 3'd4;
  localparam logic [2:0] T_UJ = 3'd5;

`ifdef ENCODER_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [32:0] q[$];
  logic [15:0] m_count = 16'd0;
  bit          m_pop;
  bit          m_push;
  int          rv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built by shifting fields into their bit positions.
  function automatic logic [32:0] model_encode(input logic [2:0] t, input logic [6:0] opc,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [4:0] rd_, input logic [4:0] rs1_,
                                               input logic [4:0] rs2_, input logic [31:0] im);
    logic [31:0] w;
    logic        e;
    int          si;
    si = $signed(im);
    e  = 1'b0;
    w  = 32'(opc) | (32'(f3) << 12);
    case (t)
      T_R:  w = w | (32'(f7) << 25) | (32'(rs2_) << 20) | (32'(rs1_) << 15) | (32'(rd_) << 7);
      T_I:  w = w | ((im & 32'hFFF) << 20) | (32'(rs1_) << 15) | (32'(rd_) << 7);
      T_S:  w = w | (((im >> 5) & 32'h7F) << 25) | (32'(rs2_) << 20) | (32'(rs1_) << 15)
                  | ((im & 32'h1F) << 7);
      T_SB: w = w | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
                  | (32'(rs2_) << 20) | (32'(rs1_) << 15) | (((im >> 1) & 32'hF) << 8)
                  | (((im >> 11) & 32'h1) << 7);
      T_U:  w = 32'(opc) | (im & 32'hFFFFF000) | (32'(rd_) << 7);
      T_UJ: w = 32'(opc) | (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                  | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                  | (32'(rd_) << 7);
      default: begin w = 32'h0; e = 1'b1; end
    endcase
    if (RC) begin
      case (t)
        T_I, T_S: e = (si < -2048) || (si > 2047);
        T_SB:     e = (si < -4096) || (si > 4094) || ((im % 2) != 0);
        T_U:      e = (im % 4096) != 0;
        T_UJ:     e = (si < -1048576) || (si > 1048574) || ((im % 2) != 0);
        default:  ;
      endcase
    end
    return {e, w};
  endfunction

  // Reference model: occupancy decided from the model's own queue.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_count = 16'd0;
    end else begin
      m_pop  = (q.size() > 0) && (bus.out_ready === 1'b1);
      m_push = (bus.in_valid === 1'b1) && (q.size() < 2);
      if (m_pop) begin
        void'(q.pop_front());
        m_count = m_count + 16'd1;
      end
      if (m_push)
        q.push_back(model_encode(bus.instruction_type, bus.opcode, bus.funct3, bus.funct7,
                                 bus.rd, bus.rs1, bus.rs2, bus.imm));
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      check("count", 64'(bus.count), 64'(m_count));
      if (q.size() > 0) begin
        check("instruction", 64'(bus.instruction), 64'(q[0][31:0]));
        check("err", 64'(bus.err), 64'(q[0][32]));
      end
    end
  end

  task automatic set_fields(input logic [2:0] t, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd_, input logic [4:0] rs1_,
                            input logic [4:0] rs2_, input logic [31:0] im);
    bus.instruction_type = t;
    bus.opcode = opc;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.rd = rd_;
    bus.rs1 = rs1_;
    bus.rs2 = rs2_;
    bus.imm = im;
  endtask

  // Hold in_valid (fields already set) until accepted; bounded wait.
  task automatic push_wait(input string name);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) check({name, "_accept_timeout"}, 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [2:0] t, input logic [6:0] opc,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd_,
                          input logic [4:0] rs1_, input logic [4:0] rs2_, input logic [31:0] im,
                          input logic [31:0] exp_w, input logic exp_e);
    check({name, "_model"}, 64'(model_encode(t, opc, f3, f7, rd_, rs1_, rs2_, im)), 64'({exp_e, exp_w}));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    set_fields(t, opc, f3, f7, rd_, rs1_, rs2_, im);
    push_wait(name);
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_word"}, 64'(bus.instruction), 64'(exp_w));
    check({name, "_err"}, 64'(bus.err), 64'(exp_e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_instruction", 64'(bus.instruction), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    reset = 1'b0;

    directed("addi", T_I, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
    directed("add", T_R, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);
    directed("lui", T_U, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
    directed("beq_m4", T_SB, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    directed("beq_3", T_SB, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h00208163, RC);
    directed("addi_2048", T_I, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h80000093, RC);
    directed("undef", 3'd7, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd5, 32'h00000000, 1'b1);

    // Backpressure: two accepted, third stalls, drains in order.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b0;
    set_fields(T_I, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    push_wait("bp1");
    set_fields(T_R, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    push_wait("bp2");
    set_fields(T_U, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_ready", 64'(bus.in_ready), 64'd0);
      check("bp_hold_word", 64'(bus.instruction), 64'h00500093);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    push_wait("bp3");
    repeat (4) @(posedge clk);
    #1;
    check("bp_count", 64'(bus.count), 64'd3);
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset while full.
    bus.out_ready = 1'b0;
    set_fields(T_I, 7'b0010011, 3'd1, 7'd0, 5'd7, 5'd2, 5'd0, 32'd9);
    push_wait("rf1");
    push_wait("rf2");
    check("rf_full", 64'(bus.in_ready), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rf_out_valid", 64'(bus.out_valid), 64'd0);
    check("rf_in_ready", 64'(bus.in_ready), 64'd1);
    check("rf_count", 64'(bus.count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rf_no_stale", 64'(bus.out_valid), 64'd0);

    // Randomized traffic.
    repeat (3000) begin
      @(posedge clk); #1;
      case ($urandom % 4)
        0: rv = int'($urandom);
        1: rv = int'($urandom_range(0, 8400)) - 4200;
        2: rv = int'($urandom_range(0, 8)) + 1048570 - (($urandom % 2 == 1) ? 2097152 + 8 : 0);
        default: rv = int'($urandom & 32'hFFFFF000) | int'($urandom % 2);
      endcase
      set_fields(3'($urandom), 7'($urandom), 3'($urandom), 7'($urandom),
                 5'($urandom), 5'($urandom), 5'($urandom), 32'(rv));
      bus.in_valid  = ($urandom % 10) < 7;
      bus.out_ready = ($urandom % 10) < 7;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("final_empty", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
